// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage: ID/EX operand A/B select with forwarding, hazard stall
// and a single-entry valid/ready pipeline slot.                   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int NFWD  = 3,
  parameter int SELW  = 3,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      rs_data,
  input  logic [WIDTH-1:0]      rt_data,
  input  logic [WIDTH-1:0]      ext_out,
  input  logic                  alusrc,
  input  logic [SELW-1:0]       sel_a,
  input  logic [SELW-1:0]       sel_b,
  input  logic [NFWD*WIDTH-1:0] fwd_data,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      a_out,
  output logic [WIDTH-1:0]      b_out,
  output logic [CNTW-1:0]       stall_cnt
);

  localparam logic [CNTW-1:0] C_CNT_MAX = {CNTW{1'b1}};

  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;
  logic             ok_a;
  logic             ok_b;
  logic             resolved;
  logic             accept;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;

  // Selects that match no forward source fall through to the register file.
  always_comb begin
    mux_a = rs_data;
    ok_a  = 1'b1;
    mux_b = rt_data;
    ok_b  = 1'b1;
    for (int k = 1; k <= NFWD; k++) begin
      if (sel_a == SELW'(k)) begin
        mux_a = fwd_data[k*WIDTH-1 -: WIDTH];
        ok_a  = fwd_valid[k-1];
      end
      if (sel_b == SELW'(k)) begin
        mux_b = fwd_data[k*WIDTH-1 -: WIDTH];
        ok_b  = fwd_valid[k-1];
      end
    end
    if (alusrc) begin
      mux_b = ext_out;
      ok_b  = 1'b1;
    end
  end

  assign resolved = ok_a & ok_b;
  assign in_ready = resolved & (~out_valid_q | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      a_d         = mux_a;
      b_d         = mux_b;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Only hazard stalls count; pure backpressure leaves the counter alone.
    if (in_valid && !resolved && !flush && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage: directed + random checks against a queue-based model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_operand_stage;

  localparam int W   = 32;
  localparam int NF  = 3;
  localparam int SW  = 3;
  localparam int CW  = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  rs_data, rt_data, ext_out;
  logic          alusrc;
  logic [SW-1:0] sel_a, sel_b;
  logic [W-1:0]  fwd [NF];
  logic [NF*W-1:0] fwd_data;
  logic [NF-1:0] fwd_valid;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  a_out, b_out;
  logic [CW-1:0] stall_cnt;

  assign fwd_data = {fwd[2], fwd[1], fwd[0]};

  alu_operand_stage #(.WIDTH(W), .NFWD(NF), .SELW(SW), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_data(rs_data), .rt_data(rt_data), .ext_out(ext_out), .alusrc(alusrc),
    .sel_a(sel_a), .sel_b(sel_b), .fwd_data(fwd_data), .fwd_valid(fwd_valid),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the slot is a queue of at most one {a,b} pair.
  logic [2*W-1:0] slot [$];
  logic [W-1:0]   last_a, last_b;
  int             m_cnt;
  int             checks = 0;
  int             passed = 0;
  int             fails  = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_sel(input logic [SW-1:0] s);
    return (int'(s) > NF) ? 0 : int'(s);
  endfunction

  function automatic logic [W-1:0] pick(input int s, input logic [W-1:0] base);
    return (s == 0) ? base : fwd[s-1];
  endfunction

  task automatic model_reset();
    slot.delete();
    last_a = '0;
    last_b = '0;
    m_cnt  = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", W'(out_valid), W'(slot.size() != 0));
    check("a_out", a_out, last_a);
    check("b_out", b_out, last_b);
    check("stall_cnt", W'(stall_cnt), W'(m_cnt));
  endtask

  task automatic drive(input bit v, input int sa, input int sb, input bit src,
                       input logic [W-1:0] rs, input logic [W-1:0] rt, input logic [W-1:0] ext,
                       input logic [NF-1:0] fv, input bit fl, input bit ordy);
    in_valid  = v;
    sel_a     = SW'(sa);
    sel_b     = SW'(sb);
    alusrc    = src;
    rs_data   = rs;
    rt_data   = rt;
    ext_out   = ext;
    fwd_valid = fv;
    flush     = fl;
    out_ready = ordy;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    int sa, sb;
    bit ok_a, ok_b, res, exp_rdy;
    logic [W-1:0] na, nb;
    #1;
    sa   = eff_sel(sel_a);
    sb   = eff_sel(sel_b);
    ok_a = (sa == 0) ? 1'b1 : fwd_valid[sa-1];
    ok_b = alusrc ? 1'b1 : ((sb == 0) ? 1'b1 : fwd_valid[sb-1]);
    res  = ok_a && ok_b;
    exp_rdy = res && (slot.size() == 0 || out_ready) && !flush;
    check("in_ready", W'(in_ready), W'(exp_rdy));
    na = pick(sa, rs_data);
    nb = alusrc ? ext_out : pick(sb, rt_data);
    @(posedge clk);
    if (flush) begin
      slot.delete();
    end else begin
      if (slot.size() != 0 && out_ready) void'(slot.pop_front());
      if (in_valid && exp_rdy) begin
        slot.push_back({na, nb});
        last_a = na;
        last_b = nb;
      end
    end
    if (in_valid && !res && !flush && m_cnt < CMAX) m_cnt++;
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    fwd[0] = '0; fwd[1] = '0; fwd[2] = '0;
    reset = 1'b0;
    drive(0, 0, 0, 0, '0, '0, '0, '0, 0, 0);
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Plain register-file operands
    drive(1, 0, 0, 0, 32'h11, 32'h22, '0, 3'b000, 0, 1);
    cycle();

    // Immediate B ignores an unresolved sel_b
    drive(1, 0, 2, 1, 32'h1, 32'h2, 32'hFFFF8000, 3'b001, 0, 1);
    cycle();

    // Hazard on forward source 1 for three cycles, then it resolves
    drive(1, 1, 0, 0, 32'h3, 32'h4, '0, 3'b000, 0, 1);
    repeat (3) cycle();
    fwd[0] = 32'hDEADBEEF;
    fwd_valid = 3'b001;
    cycle();
    in_valid = 1'b0;
    cycle();

    // Backpressure, then release with no bubble
    drive(1, 0, 0, 0, 32'h5, 32'h6, '0, 3'b000, 0, 0);
    cycle();
    drive(1, 0, 0, 0, 32'h7, 32'h8, '0, 3'b000, 0, 0);
    cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();

    // Flush overrides both the held pair and the incoming one
    drive(1, 0, 0, 0, 32'h9, 32'hA, '0, 3'b000, 0, 0);
    cycle();
    drive(1, 0, 0, 0, 32'hAA, 32'hBB, '0, 3'b000, 1, 0);
    cycle();

    // Out-of-range select falls back to the register file
    drive(1, 7, 0, 0, 32'h77, 32'h88, '0, 3'b000, 0, 1);
    cycle();
    drive(1, 0, 5, 0, 32'h12, 32'h34, '0, 3'b000, 0, 1);
    cycle();

    // Counter saturation with a held pair, then asynchronous reset mid-stall
    drive(1, 0, 0, 0, 32'h5, 32'h6, '0, 3'b000, 0, 0);
    cycle();
    drive(1, 1, 3, 0, 32'h1, 32'h2, '0, 3'b000, 0, 0);
    repeat (20) cycle();
    check("stall_sat", W'(stall_cnt), W'(CMAX));
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NF; k++) fwd[k] = $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom, $urandom, $urandom,
            NF'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised successor to the single-cycle ALU source mux; sits at the ID/EX boundary of the pipelined CPU.
- Selects operand A and operand B for each instruction. Each comes from the register file or one of NFWD forwarding sources. Operand B can also be the extended immediate.
- Registers the selected pair into a single-entry pipeline slot under a valid/ready handshake.
- Stalls when a selected forward source is not yet valid, and counts stall cycles.

Parameters:
- WIDTH, 32, operand width in bits.
- NFWD, 3, number of forwarding sources (1..7).
- SELW, 3, width of the sel_a/sel_b fields; must satisfy 2^SELW > NFWD.
- CNTW, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- rs_data  in  WIDTH  register-file read data 1.
- rt_data  in  WIDTH  register-file read data 2.
- ext_out  in  WIDTH  extended immediate.
- alusrc  in  1  1 = operand B is ext_out.
- sel_a  in  SELW  0 = rs_data; k in 1..NFWD = forward source k.
- sel_b  in  SELW  0 = rt_data; k in 1..NFWD = forward source k.
- fwd_data  in  NFWD*WIDTH  flattened forward values; source k occupies bits [k*WIDTH-1:(k-1)*WIDTH].
- fwd_valid  in  NFWD  bit k-1 = forward source k holds a final value.
- flush  in  1  discard the held and incoming instruction.
- out_valid  out  1  A/B hold a valid operand pair.
- out_ready  in  1  downstream (EX) consumes the pair.
- a_out  out  WIDTH  registered operand A.
- b_out  out  WIDTH  registered operand B.
- stall_cnt  out  CNTW  saturating count of hazard-stall cycles.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, a_out=0, b_out=0, stall_cnt=0. Reset takes effect immediately, mid-transfer included; any held pair is lost.
- Out-of-range select: a sel value greater than NFWD is treated as 0 (register-file source).
- Operand A resolution: ok_a = (sel_a==0) or fwd_valid[sel_a-1].
- Operand B resolution: ok_b = alusrc or (sel_b==0) or fwd_valid[sel_b-1]. When alusrc=1, sel_b is ignored completely.
- resolved = ok_a & ok_b.
- Value selection: mux_a = sel_a==0 ? rs_data : fwd source sel_a. mux_b = alusrc ? ext_out : (sel_b==0 ? rt_data : fwd source sel_b). Selection is purely bitwise; no arithmetic, no sign handling.
- in_ready = resolved & (!out_valid | out_ready) & !flush. This is combinational and must not depend on in_valid.
- Accept: in_valid & in_ready. On the next edge, a_out<=mux_a, b_out<=mux_b, out_valid<=1.
- Drain: out_valid & out_ready with no accept in the same cycle gives out_valid<=0 next edge. a_out/b_out keep their last values.
- Simultaneous drain + accept: the new pair replaces the old with no bubble, giving full throughput of 1 pair per cycle.
- Backpressure: while out_valid & !out_ready, a_out/b_out/out_valid stay stable and in_ready=0.
- Flush: on the next edge, out_valid<=0 and nothing is accepted. This overrides accept and drain. a_out/b_out are unchanged.
- Stall counter:
  - Increments on each edge where in_valid & !resolved & !flush.
  - Saturates at all-ones; no wrap-around.
  - Cycles blocked only by backpressure are not counted.
- Latency: 1 cycle from accept to out_valid.

Test Plan:
- Reset, then in_valid=1, sel_a=0, sel_b=0, alusrc=0, rs=0x11, rt=0x22, out_ready=1 -> next cycle out_valid=1, a_out=0x11, b_out=0x22; stall_cnt=0.
- alusrc=1, ext_out=0xFFFF8000, sel_b=2 with fwd_valid[1]=0 -> in_ready=1, b_out=0xFFFF8000, no stall counted.
- sel_a=1, fwd_valid=000 for 3 cycles, then 001 with fwd1=0xDEADBEEF -> in_ready=0 for 3 cycles, stall_cnt=3, then a_out=0xDEADBEEF.
- out_ready=0 with pair 0x5/0x6 held while upstream offers 0x7/0x8 -> outputs hold 0x5/0x6 and in_ready=0; raise out_ready -> 0x7/0x8 appear the next cycle with no bubble.
- flush asserted while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, no accept, a_out unchanged.
- sel_a=7 with NFWD=3 -> rs_data selected. With CNTW=4, hold an unresolved hazard 20 cycles -> stall_cnt stays 0xF. Pulse reset low mid-stall -> all outputs 0 immediately.
